// File: rtl/pipe_pkg.sv
// Shared definitions for the dual-issue pipeline register slice.
//   state_e     : occupancy state of a two-entry (MAIN + SKID) pipeline stage;
//                 the encoding doubles as the bundle count.
//   bundle_bits : stored width of one bundle, valid + tag + payload per lane.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_e;

    function automatic int unsigned bundle_bits(
        input int unsigned lanes,
        input int unsigned num_w,
        input int unsigned width
    );
        return lanes * (1 + num_w + width);
    endfunction

endpackage

// File: rtl/pipe_bundle_entry.sv
// One bundle register (LANES slots of valid/tag/payload).
// Ports:
//   clk, rst   : clock, synchronous active-high reset (zeroes everything)
//   i_clear    : zero the whole entry (flush)
//   i_load     : capture i_valid/i_num/i_data
//   i_kill     : per-lane valid clear when not loading; tag/payload hold
//   o_valid, o_num, o_data : stored bundle
// Priority: rst/i_clear > i_load > i_kill.
module pipe_bundle_entry
    import pipe_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned NUM_W = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_clear,
    input  logic                   i_load,
    input  logic [LANES-1:0]       i_kill,
    input  logic [LANES-1:0]       i_valid,
    input  logic [LANES*NUM_W-1:0] i_num,
    input  logic [LANES*WIDTH-1:0] i_data,
    output logic [LANES-1:0]       o_valid,
    output logic [LANES*NUM_W-1:0] o_num,
    output logic [LANES*WIDTH-1:0] o_data
);

    localparam int unsigned BW = bundle_bits(LANES, NUM_W, WIDTH);

    // Layout, MSB first: {valid, tag, payload}
    logic [BW-1:0] r_bundle;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_bundle <= '0;
        end else if (i_load) begin
            r_bundle <= {i_valid, i_num, i_data};
        end else begin
            r_bundle[BW-1 -: LANES] <= r_bundle[BW-1 -: LANES] & ~i_kill;
        end
    end

    assign o_valid = r_bundle[BW-1 -: LANES];
    assign o_num   = r_bundle[LANES*WIDTH +: LANES*NUM_W];
    assign o_data  = r_bundle[LANES*WIDTH-1:0];

endmodule

// File: rtl/dual_issue_pipe_reg.sv
// Dual-issue pipeline register with valid/ready handshake and a 2-entry skid
// buffer (MAIN drives the outputs, SKID catches the bundle accepted while MAIN
// is blocked), so in_ready is a pure register.
// Ports:
//   clk, rst                      : clock, synchronous active-high reset
//   in_valid/in_num/in_data       : incoming bundle (all-zero in_valid = bubble)
//   in_ready                      : registered, low only while both entries full
//   out_valid/out_num/out_data    : presented bundle (MAIN entry)
//   out_ready, stall              : downstream accept; stall masks out_ready
//   flush                         : drop both entries and any incoming bundle
//   kill_mask                     : clear selected lanes of MAIN
//   occupancy                     : bundles held (0..2)
//   stall_cnt                     : saturating count of cycles with valid
//                                   output that did not drain
module dual_issue_pipe_reg
    import pipe_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned WIDTH = 64,
    parameter int unsigned NUM_W = 1,
    parameter int unsigned CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [LANES-1:0]       in_valid,
    input  logic [LANES*NUM_W-1:0] in_num,
    input  logic [LANES*WIDTH-1:0] in_data,
    output logic                   in_ready,
    output logic [LANES-1:0]       out_valid,
    output logic [LANES*NUM_W-1:0] out_num,
    output logic [LANES*WIDTH-1:0] out_data,
    input  logic                   out_ready,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [LANES-1:0]       kill_mask,
    output logic [1:0]             occupancy,
    output logic [CNT_W-1:0]       stall_cnt
);

    state_e                 r_state;
    state_e                 w_state_nxt;
    logic                   r_in_ready;
    logic [CNT_W-1:0]       r_stall_cnt;

    logic [LANES-1:0]       w_main_valid;
    logic [LANES*NUM_W-1:0] w_main_num;
    logic [LANES*WIDTH-1:0] w_main_data;
    logic [LANES-1:0]       w_skid_valid;
    logic [LANES*NUM_W-1:0] w_skid_num;
    logic [LANES*WIDTH-1:0] w_skid_data;

    logic                   w_accept;
    logic                   w_drain;
    logic                   w_kill_empty;
    logic                   w_leave;
    logic                   w_main_load;
    logic                   w_main_from_skid;
    logic                   w_skid_load;
    logic                   w_skid_drop;
    logic [LANES-1:0]       w_main_kill;
    logic [LANES-1:0]       w_skid_kill;
    logic [LANES-1:0]       w_main_in_valid;
    logic [LANES*NUM_W-1:0] w_main_in_num;
    logic [LANES*WIDTH-1:0] w_main_in_data;

    assign w_accept = r_in_ready & (|in_valid);
    assign w_drain  = (|w_main_valid) & out_ready & ~stall;

    // A kill that removes every remaining lane of MAIN frees it just like a
    // drain, so both paths share the same state transitions.
    assign w_kill_empty = (|w_main_valid) & ~w_drain
                        & ((w_main_valid & ~kill_mask) == '0);
    assign w_leave      = w_drain | w_kill_empty;

    // When MAIN leaves without being reloaded, only its valid bits drop; the
    // tag/payload hold their last values. Any load overrides this kill.
    assign w_main_kill = w_leave ? '1 : kill_mask;
    assign w_skid_kill = w_skid_drop ? '1 : '0;

    always_comb begin
        w_state_nxt      = r_state;
        w_main_load      = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_load      = 1'b0;
        w_skid_drop      = 1'b0;
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_state_nxt = ST_ONE;
                        w_main_load = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_leave) begin
                        w_main_load = 1'b1;
                    end else if (w_accept) begin
                        w_state_nxt = ST_TWO;
                        w_skid_load = 1'b1;
                    end else if (w_leave) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_leave) begin
                        w_state_nxt      = ST_ONE;
                        w_main_load      = 1'b1;
                        w_main_from_skid = 1'b1;
                        w_skid_drop      = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    assign w_main_in_valid = w_main_from_skid ? w_skid_valid : in_valid;
    assign w_main_in_num   = w_main_from_skid ? w_skid_num   : in_num;
    assign w_main_in_data  = w_main_from_skid ? w_skid_data  : in_data;

    pipe_bundle_entry #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .NUM_W (NUM_W)
    ) u_main (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush),
        .i_load  (w_main_load),
        .i_kill  (w_main_kill),
        .i_valid (w_main_in_valid),
        .i_num   (w_main_in_num),
        .i_data  (w_main_in_data),
        .o_valid (w_main_valid),
        .o_num   (w_main_num),
        .o_data  (w_main_data)
    );

    pipe_bundle_entry #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .NUM_W (NUM_W)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_clear (flush),
        .i_load  (w_skid_load),
        .i_kill  (w_skid_kill),
        .i_valid (in_valid),
        .i_num   (in_num),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_num   (w_skid_num),
        .o_data  (w_skid_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
        end
    end

    // Counts regardless of flush; only reset clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if ((|w_main_valid) && !w_drain && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = w_main_valid;
    assign out_num   = w_main_num;
    assign out_data  = w_main_data;
    assign occupancy = r_state;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_dual_issue_pipe_reg.sv
module tb_dual_issue_pipe_reg;

    localparam int unsigned LANES = 2;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned NUM_W = 1;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned CMAX  = 15;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [LANES-1:0]       in_valid = '0;
    logic [LANES*NUM_W-1:0] in_num = '0;
    logic [LANES*WIDTH-1:0] in_data = '0;
    logic                   in_ready;
    logic [LANES-1:0]       out_valid;
    logic [LANES*NUM_W-1:0] out_num;
    logic [LANES*WIDTH-1:0] out_data;
    logic                   out_ready = 1'b0;
    logic                   stall = 1'b0;
    logic                   flush = 1'b0;
    logic [LANES-1:0]       kill_mask = '0;
    logic [1:0]             occupancy;
    logic [CNT_W-1:0]       stall_cnt;

    always #5 clk = ~clk;

    dual_issue_pipe_reg #(
        .LANES (LANES),
        .WIDTH (WIDTH),
        .NUM_W (NUM_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_num    (in_num),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_num   (out_num),
        .out_data  (out_data),
        .out_ready (out_ready),
        .stall     (stall),
        .flush     (flush),
        .kill_mask (kill_mask),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    typedef struct packed {
        logic [1:0]  v;
        logic [1:0]  n;
        logic [63:0] d;
    } bun_t;

    bun_t        q[$];
    int unsigned cnt_m = 0;
    bit          zflag = 1'b1;
    bit          last_acc = 1'b0;
    int          errors = 0;
    int          checks = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Compare present outputs with the scoreboard, advance the model with the
    // currently driven inputs, then move one cycle (sampling #1 after the edge).
    task automatic tick();
        bun_t f;
        bit   rdy, acc, drn;
        if (q.size() > 0) begin
            f = q[0];
            chk("out_valid", 64'(out_valid), 64'(f.v));
            chk("out_num",   64'(out_num),   64'(f.n));
            chk("out_data",  64'(out_data),  f.d);
        end else begin
            chk("out_valid_idle", 64'(out_valid), 64'd0);
            if (zflag) begin
                chk("out_data_zero", 64'(out_data), 64'd0);
                chk("out_num_zero",  64'(out_num),  64'd0);
            end
        end
        chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
        chk("occupancy", 64'(occupancy), 64'(q.size()));
        chk("stall_cnt", 64'(stall_cnt), 64'(cnt_m));

        rdy = (q.size() < 2);
        acc = rdy && (|in_valid) && !rst && !flush;
        drn = (q.size() > 0) && out_ready && !stall;
        if (rst) begin
            q.delete();
            cnt_m = 0;
            zflag = 1'b1;
        end else begin
            if (q.size() > 0 && !drn && cnt_m < CMAX) cnt_m++;
            if (flush) begin
                q.delete();
                zflag = 1'b1;
            end else begin
                if (drn) begin
                    void'(q.pop_front());
                end else if (q.size() > 0) begin
                    f = q[0];
                    f.v = f.v & ~kill_mask;
                    if (f.v == 2'b00) void'(q.pop_front());
                    else q[0] = f;
                end
                if (acc) begin
                    q.push_back({in_valid, in_num, in_data});
                    zflag = 1'b0;
                end
            end
        end
        last_acc = acc;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] n, input logic [63:0] d);
        in_valid = v;
        in_num   = n;
        in_data  = d;
    endtask

    initial begin
        // reset: two cycles, model starts empty with zeroed outputs
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);

        // streaming: one bundle per cycle with out_ready held high
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            drive(2'b11, 2'b10, {32'(32'h22 + k), 32'(32'h11 + k)});
            tick();
        end
        drive(2'b00, 2'b00, 64'd0);
        tick();
        tick();

        // backpressure: A, B fill both entries, C must wait upstream
        out_ready = 1'b0;
        drive(2'b11, 2'b01, 64'h000000A1_000000A0);
        tick();
        drive(2'b01, 2'b10, 64'h000000B1_000000B0);
        tick();
        drive(2'b10, 2'b11, 64'h000000C1_000000C0);
        tick();
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_occ", 64'(occupancy), 64'd2);
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (last_acc) break;
        end
        chk("c_accepted", 64'(last_acc), 64'd1);
        drive(2'b00, 2'b00, 64'd0);
        repeat (4) tick();

        // flush while full, with a same-cycle incoming bundle
        out_ready = 1'b0;
        drive(2'b11, 2'b00, 64'h11111111_10101010);
        tick();
        drive(2'b11, 2'b01, 64'h22222222_20202020);
        tick();
        drive(2'b11, 2'b11, 64'h33333333_30303030);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(2'b00, 2'b00, 64'd0);
        chk("flush_valid", 64'(out_valid), 64'd0);
        chk("flush_data", 64'(out_data), 64'd0);
        chk("flush_ready", 64'(in_ready), 64'd1);
        tick();

        // per-lane kill on MAIN with SKID loaded
        drive(2'b11, 2'b10, 64'hAAAA0001_55550001);
        tick();
        drive(2'b11, 2'b01, 64'hAAAA0002_55550002);
        tick();
        drive(2'b00, 2'b00, 64'd0);
        kill_mask = 2'b10;
        tick();
        chk("kill_valid", 64'(out_valid), 64'd1);
        chk("kill_lane0", 64'(out_data[31:0]), 64'h55550001);
        kill_mask = 2'b01;
        tick();
        chk("kill_promote_occ", 64'(occupancy), 64'd1);
        chk("kill_promote_data", 64'(out_data), 64'hAAAA0002_55550002);
        kill_mask = 2'b00;
        tick();

        // random traffic against the scoreboard
        for (int i = 0; i < 200; i++) begin
            drive(2'($urandom), 2'($urandom), {$urandom, $urandom});
            out_ready = 1'($urandom);
            stall     = ($urandom_range(7) == 0);
            kill_mask = ($urandom_range(7) == 0) ? 2'($urandom) : 2'b00;
            flush     = ($urandom_range(31) == 0);
            tick();
        end
        drive(2'b00, 2'b00, 64'd0);
        stall = 1'b0;
        kill_mask = 2'b00;
        flush = 1'b0;

        // stall counter saturation from a fresh reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        out_ready = 1'b1;
        stall = 1'b1;
        drive(2'b11, 2'b10, 64'h0000BEEF_0000CAFE);
        tick();
        drive(2'b00, 2'b00, 64'd0);
        repeat (20) tick();
        chk("stall_sat", 64'(stall_cnt), 64'd15);
        stall = 1'b0;
        tick();
        tick();
        chk("stall_hold", 64'(stall_cnt), 64'd15);
        chk("stall_drained", 64'(occupancy), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
